// File: rtl/nand_ecc_pkg.sv
// Shared encodings and FSM state constants for the NAND page ECC sequencer.
package nand_ecc_pkg;

    typedef enum logic [1:0] {
        CLEAN   = 2'd0,
        CORR    = 2'd1,
        ECC_ERR = 2'd2,
        UNCORR  = 2'd3
    } ecc_status_e;

    localparam int CHUNK_BYTES = 512;
    localparam int SYN_W       = 24;
    localparam int CORR_WEIGHT = 12;
    localparam int BYTE_W      = $clog2(CHUNK_BYTES);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_ECC = 3'd1;
    localparam logic [2:0] S_CLASSIFY = 3'd2;
    localparam logic [2:0] S_RD       = 3'd3;
    localparam logic [2:0] S_RD_WAIT  = 3'd4;
    localparam logic [2:0] S_WR       = 3'd5;
    localparam logic [2:0] S_NEXT     = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

endpackage

// File: rtl/nand_ecc_syn_decode.sv
// Combinational Hamming syndrome decode: weight, complementarity,
// chunk classification and faulty byte/bit position.
module nand_ecc_syn_decode
    import nand_ecc_pkg::*;
(
    input  logic [SYN_W-1:0]  syn,
    output ecc_status_e       cls,
    output logic [BYTE_W-1:0] byte_idx,
    output logic [2:0]        bit_idx
);

    logic [4:0] weight;
    logic       compl_ok;

    always_comb begin
        weight   = '0;
        compl_ok = 1'b1;
        for (int i = 0; i < SYN_W; i++) begin
            weight = weight + 5'(syn[i]);
        end
        for (int k = 0; k < SYN_W / 2; k++) begin
            compl_ok = compl_ok & (syn[2*k] ^ syn[2*k+1]);
        end
    end

    // Odd syndrome bits carry the position: three for the bit, nine for the byte.
    always_comb begin
        byte_idx = '0;
        for (int j = 0; j < BYTE_W; j++) begin
            byte_idx[j] = syn[7 + 2*j];
        end
    end

    assign bit_idx = {syn[5], syn[3], syn[1]};

    always_comb begin
        cls = UNCORR;
        if (weight == 5'd0)
            cls = CLEAN;
        else if (weight == 5'(CORR_WEIGHT) && compl_ok)
            cls = CORR;
        else if (weight == 5'd1)
            cls = ECC_ERR;
    end

endmodule

// File: rtl/nand_ecc_ctrl.sv
// Page-level ECC sequencer: classifies each chunk and fixes single-bit data
// errors by read-modify-write. NAND_ECC_STATS_EN adds CORR/UNCORR counters.
//
// state      | meaning
// IDLE       | waiting for start
// WAIT_ECC   | ecc_ready high, waiting for the ECC pair
// CLASSIFY   | record chunk status, pick correction or skip
// RD         | read the faulty byte
// RD_WAIT    | capture read data
// WR         | write the byte back with the bad bit flipped
// NEXT       | advance chunk or finish
// DONE       | one-cycle done pulse
module nand_ecc_ctrl
    import nand_ecc_pkg::*;
#(
    parameter int CHUNKS = 4,
    parameter int ADDR_W = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  ecc_valid,
    output logic                  ecc_ready,
    input  logic [SYN_W-1:0]      ecc_calc,
    input  logic [SYN_W-1:0]      ecc_stored,
    output logic                  buf_rd,
    output logic                  buf_wr,
    output logic [ADDR_W-1:0]     buf_addr,
    input  logic [7:0]            buf_rdata,
    output logic [7:0]            buf_wdata,
    output logic                  busy,
    output logic                  done,
    output logic [2*CHUNKS-1:0]   status,
    output logic                  page_uncorr
`ifdef NAND_ECC_STATS_EN
    ,
    input  logic                  clr_stats,
    output logic [15:0]           corr_total,
    output logic [15:0]           uncorr_total
`endif
);

    localparam int CHUNK_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    logic [2:0]         state_q;
    logic [CHUNK_W-1:0] chunk_q;
    logic [SYN_W-1:0]   syn_q;
    logic [7:0]         rdata_q;
    logic [ADDR_W-1:0]  addr_q;

    ecc_status_e        cls;
    logic [BYTE_W-1:0]  byte_idx;
    logic [2:0]         bit_idx;

    nand_ecc_syn_decode u_decode (
        .syn      (syn_q),
        .cls      (cls),
        .byte_idx (byte_idx),
        .bit_idx  (bit_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            chunk_q     <= '0;
            syn_q       <= '0;
            rdata_q     <= '0;
            addr_q      <= '0;
            status      <= '0;
            page_uncorr <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        status      <= '0;
                        page_uncorr <= 1'b0;
                        chunk_q     <= '0;
                        state_q     <= S_WAIT_ECC;
                    end
                end
                S_WAIT_ECC: begin
                    if (ecc_valid) begin
                        syn_q   <= ecc_calc ^ ecc_stored;
                        state_q <= S_CLASSIFY;
                    end
                end
                S_CLASSIFY: begin
                    status[2*int'(chunk_q) +: 2] <= cls;
                    addr_q <= ADDR_W'({chunk_q, byte_idx});
                    if (cls == CORR) begin
                        state_q <= S_RD;
                    end else begin
                        if (cls == UNCORR)
                            page_uncorr <= 1'b1;
                        state_q <= S_NEXT;
                    end
                end
                S_RD:      state_q <= S_RD_WAIT;
                S_RD_WAIT: begin
                    rdata_q <= buf_rdata;
                    state_q <= S_WR;
                end
                S_WR:      state_q <= S_NEXT;
                S_NEXT: begin
                    if (chunk_q == CHUNK_W'(CHUNKS - 1)) begin
                        state_q <= S_DONE;
                    end else begin
                        chunk_q <= chunk_q + 1'b1;
                        state_q <= S_WAIT_ECC;
                    end
                end
                S_DONE:    state_q <= S_IDLE;
                default:   state_q <= S_IDLE;
            endcase
        end
    end

    // Strobes decode straight from state so a reset drops them immediately.
    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = (state_q == S_DONE);
    assign ecc_ready = (state_q == S_WAIT_ECC);
    assign buf_rd    = (state_q == S_RD);
    assign buf_wr    = (state_q == S_WR);
    assign buf_addr  = (buf_rd || buf_wr) ? addr_q : '0;
    assign buf_wdata = buf_wr ? (rdata_q ^ (8'h01 << bit_idx)) : 8'h00;

`ifdef NAND_ECC_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_total   <= '0;
            uncorr_total <= '0;
        end else if (clr_stats) begin
            corr_total   <= '0;
            uncorr_total <= '0;
        end else if (state_q == S_CLASSIFY) begin
            if (cls == CORR && corr_total != 16'hFFFF)
                corr_total <= corr_total + 16'd1;
            if (cls == UNCORR && uncorr_total != 16'hFFFF)
                uncorr_total <= uncorr_total + 16'd1;
        end
    end
`endif

endmodule
